// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 compression sequencer.
// The IV and K words here are also used by the H register and round datapath.
package sha256_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_ROUND,
    S_UPDATE,
    S_DONE
  } state_t;

  localparam int ROUNDS_DEFAULT = 64;
  localparam int TW_DEFAULT     = 6;
  localparam int CNT_W_DEFAULT  = 16;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_of(input logic [5:0] t);
    return K[t];
  endfunction

  function automatic logic [31:0] iv_of(input logic [2:0] i);
    return IV[i];
  endfunction

endpackage

// File: rtl/sha256_round_cnt.sv
// Round index counter: clears, advances on enable and wraps to 0
// after ROUNDS-1, so the index never reaches an illegal value.
module sha256_round_cnt #(
  parameter int ROUNDS = 64,
  parameter int TW     = 6
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [TW-1:0] o_t,
  output logic          o_tc
);

  localparam logic [TW-1:0] LAST = TW'(ROUNDS - 1);

  logic [TW-1:0] r_t;
  logic          w_tc;

  assign w_tc = (r_t == LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_t <= '0;
    end else if (i_clr) begin
      r_t <= '0;
    end else if (i_en) begin
      r_t <= w_tc ? '0 : r_t + TW'(1);
    end
  end

  assign o_t  = r_t;
  assign o_tc = w_tc;

endmodule

// File: rtl/sha256_sched_ctrl.sv
// Block sequencer for one SHA-256 compression core: owns the H init,
// working-variable load, round enable and H update strobes.
module sha256_sched_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT,
  parameter int TW     = TW_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_blk_valid,
  input  logic             i_blk_last,
  output logic             o_blk_ready,
  input  logic             i_abort,
  output logic             o_h_init,
  output logic             o_wv_load,
  output logic             o_round_en,
  output logic [TW-1:0]    o_round_t,
  output logic             o_h_update,
  output logic             o_digest_valid,
  input  logic             i_digest_ack,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_blk_cnt
);

  state_t           r_state;
  logic             r_first;
  logic             r_last_q;
  logic             r_blk_ready;
  logic             r_h_init;
  logic             r_wv_load;
  logic             r_round_en;
  logic             r_h_update;
  logic             r_dv;
  logic             r_busy;
  logic [CNT_W-1:0] r_blk_cnt;

  logic             w_abort;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_tc;
  logic [TW-1:0]    w_t;

  // abort only matters while a block is in flight; DONE treats it as ack
  assign w_abort = i_abort &&
                   (r_state == S_INIT || r_state == S_LOAD ||
                    r_state == S_ROUND || r_state == S_UPDATE);

  assign w_cnt_clr = (r_state == S_LOAD) || w_abort;
  assign w_cnt_en  = (r_state == S_ROUND);

  sha256_round_cnt #(
    .ROUNDS (ROUNDS),
    .TW     (TW)
  ) u_round_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_t     (w_t),
    .o_tc    (w_tc)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_first     <= 1'b1;
      r_last_q    <= 1'b0;
      r_blk_ready <= 1'b0;
      r_h_init    <= 1'b0;
      r_wv_load   <= 1'b0;
      r_round_en  <= 1'b0;
      r_h_update  <= 1'b0;
      r_dv        <= 1'b0;
      r_busy      <= 1'b0;
      r_blk_cnt   <= '0;
    end else begin
      r_h_init   <= 1'b0;
      r_wv_load  <= 1'b0;
      r_round_en <= 1'b0;
      r_h_update <= 1'b0;
      if (w_abort) begin
        r_state     <= S_IDLE;
        r_first     <= 1'b1;
        r_blk_ready <= 1'b1;
        r_busy      <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_blk_ready <= 1'b1;
            if (i_blk_valid && r_blk_ready) begin
              r_last_q    <= i_blk_last;
              r_blk_ready <= 1'b0;
              r_busy      <= 1'b1;
              if (r_first) begin
                r_state  <= S_INIT;
                r_h_init <= 1'b1;
              end else begin
                r_state   <= S_LOAD;
                r_wv_load <= 1'b1;
              end
            end
          end
          S_INIT: begin
            r_blk_cnt <= '0;
            r_first   <= 1'b0;
            r_state   <= S_LOAD;
            r_wv_load <= 1'b1;
          end
          S_LOAD: begin
            r_state    <= S_ROUND;
            r_round_en <= 1'b1;
          end
          S_ROUND: begin
            if (w_tc) begin
              r_state    <= S_UPDATE;
              r_h_update <= 1'b1;
            end else begin
              r_round_en <= 1'b1;
            end
          end
          S_UPDATE: begin
            r_blk_cnt <= r_blk_cnt + CNT_W'(1);
            if (r_last_q) begin
              r_state <= S_DONE;
              r_dv    <= 1'b1;
            end else begin
              r_state     <= S_IDLE;
              r_blk_ready <= 1'b1;
              r_busy      <= 1'b0;
            end
          end
          S_DONE: begin
            if (i_digest_ack || i_abort) begin
              r_state     <= S_IDLE;
              r_first     <= 1'b1;
              r_dv        <= 1'b0;
              r_blk_ready <= 1'b1;
              r_busy      <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_blk_ready    = r_blk_ready;
  assign o_h_init       = r_h_init;
  assign o_wv_load      = r_wv_load;
  assign o_round_en     = r_round_en;
  assign o_round_t      = w_t;
  assign o_h_update     = r_h_update;
  assign o_digest_valid = r_dv;
  assign o_busy         = r_busy;
  assign o_blk_cnt      = r_blk_cnt;

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// Randomized scenario bench for sha256_sched_ctrl; expected event cycles
// are derived from the block timeline (accept + fixed phase lengths).
module tb_sha256_sched_ctrl;

  localparam int R = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        blk_valid, blk_last, abort, digest_ack;
  logic        blk_ready, h_init, wv_load, round_en, h_update;
  logic        digest_valid, busy;
  logic [5:0]  round_t;
  logic [15:0] blk_cnt;

  logic        v2, l2, ab2, ack2;
  logic        rdy2, hi2, wl2, re2, hu2, dv2, bz2;
  logic [2:0]  rt2;
  logic [15:0] bc2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int n_hinit, n_load, n_round, n_upd, n_dv;
  int c_hinit, c_load, c_dv;
  int rt_next, rt_bad;
  int excl_bad = 0;
  int busy_bad = 0;
  bit chk_busy = 0;
  bit dv_prev = 0;
  int q_upd[$];

  always #5 clk = ~clk;

  sha256_sched_ctrl dut (
    .i_clk(clk), .i_reset(reset),
    .i_blk_valid(blk_valid), .i_blk_last(blk_last),
    .o_blk_ready(blk_ready), .i_abort(abort),
    .o_h_init(h_init), .o_wv_load(wv_load),
    .o_round_en(round_en), .o_round_t(round_t),
    .o_h_update(h_update), .o_digest_valid(digest_valid),
    .i_digest_ack(digest_ack), .o_busy(busy),
    .o_blk_cnt(blk_cnt)
  );

  sha256_sched_ctrl #(.ROUNDS(8), .TW(3), .CNT_W(16)) dut8 (
    .i_clk(clk), .i_reset(reset),
    .i_blk_valid(v2), .i_blk_last(l2),
    .o_blk_ready(rdy2), .i_abort(ab2),
    .o_h_init(hi2), .o_wv_load(wl2),
    .o_round_en(re2), .o_round_t(rt2),
    .o_h_update(hu2), .o_digest_valid(dv2),
    .i_digest_ack(ack2), .o_busy(bz2),
    .o_blk_cnt(bc2)
  );

  task automatic clear_rec();
    n_hinit = 0; n_load = 0; n_round = 0; n_upd = 0; n_dv = 0;
    c_hinit = -1; c_load = -1; c_dv = -1;
    rt_next = 0; rt_bad = 0;
    q_upd.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (h_init) begin n_hinit++; c_hinit = cyc; end
    if (wv_load) begin n_load++; c_load = cyc; rt_next = 0; end
    if (round_en) begin
      n_round++;
      if (round_t !== 6'(rt_next)) rt_bad++;
      rt_next++;
    end
    if (h_update) begin n_upd++; q_upd.push_back(cyc); end
    if (digest_valid && !dv_prev) begin n_dv++; c_dv = cyc; end
    dv_prev = digest_valid;
    if (int'(h_init) + int'(wv_load) + int'(round_en) + int'(h_update) > 1)
      excl_bad++;
    if (chk_busy && (busy === blk_ready)) busy_bad++;
  endtask

  task automatic offer_block(input bit last, input int maxw,
                             output int acc, output bit ok);
    blk_valid = 1'b1;
    blk_last  = last;
    ok  = 1'b0;
    acc = -1;
    for (int i = 0; i < maxw; i++) begin
      if (blk_ready) begin
        acc = cyc;
        ok  = 1'b1;
        tick();
        break;
      end
      tick();
    end
    blk_valid = 1'b0;
    blk_last  = 1'b0;
  endtask

  task automatic wait_ready(input int maxw, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxw; i++) begin
      if (blk_ready) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_dv(input int maxw, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxw; i++) begin
      if (digest_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic ack_digest();
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    blk_valid = 0; blk_last = 0; abort = 0; digest_ack = 0;
    v2 = 0; l2 = 0; ab2 = 0; ack2 = 0;
    chk_busy = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({h_init, wv_load, round_en, h_update, digest_valid, busy, blk_ready}
        !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0",
               {h_init, wv_load, round_en, h_update, digest_valid, busy, blk_ready});
    end
    checks++;
    if (round_t !== 6'd0 || blk_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_counters round_t=%0d blk_cnt=%0d want=0", round_t, blk_cnt);
    end
    reset = 1'b0;
    clear_rec();
    tick();
    checks++;
    if (blk_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release ready=%b busy=%b want ready=1 busy=0", blk_ready, busy);
    end
    chk_busy = 1;
  endtask

  task automatic test_single_block();
    int acc;
    bit ok;
    int u;
    clear_rec();
    repeat ($urandom_range(0, 4)) tick();
    offer_block(1'b1, 10, acc, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_accept got=timeout want=accept"); end
    wait_dv(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_dv got=timeout want=digest_valid"); end
    checks++;
    if (c_hinit !== acc + 1 || n_hinit !== 1) begin
      failures++;
      $display("FAIL single_hinit cyc=%0d n=%0d want cyc=%0d n=1", c_hinit, n_hinit, acc + 1);
    end
    checks++;
    if (c_load !== acc + 2) begin
      failures++;
      $display("FAIL single_load got=%0d want=%0d", c_load, acc + 2);
    end
    checks++;
    if (n_round !== R || rt_bad !== 0) begin
      failures++;
      $display("FAIL single_rounds n=%0d bad_idx=%0d want n=%0d bad_idx=0", n_round, rt_bad, R);
    end
    u = (q_upd.size() > 0) ? q_upd[0] : -1;
    checks++;
    if (q_upd.size() !== 1 || u !== acc + 67) begin
      failures++;
      $display("FAIL single_update n=%0d cyc=%0d want n=1 cyc=%0d", q_upd.size(), u, acc + 67);
    end
    checks++;
    if (c_dv !== acc + 68 || blk_cnt !== 16'd1) begin
      failures++;
      $display("FAIL single_digest cyc=%0d cnt=%0d want cyc=%0d cnt=1", c_dv, blk_cnt, acc + 68);
    end
    ack_digest();
    checks++;
    if (digest_valid !== 1'b0 || blk_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ack dv=%b ready=%b want dv=0 ready=1", digest_valid, blk_ready);
    end
  endtask

  task automatic test_back_to_back(input int nblk, input bit rnd);
    int acc_q[$];
    int acc;
    int gap;
    int want;
    int got;
    bit ok;
    clear_rec();
    for (int i = 0; i < nblk; i++) begin
      wait_ready(200, ok);
      gap = rnd ? int'($urandom_range(0, 3)) : 0;
      repeat (gap) tick();
      offer_block(i == nblk - 1, 200, acc, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL b2b_accept blk=%0d got=timeout want=accept", i); end
      acc_q.push_back(acc);
    end
    wait_dv(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_dv got=timeout want=digest_valid"); end
    for (int i = 0; i < nblk; i++) begin
      want = acc_q[i] + ((i == 0) ? 67 : 66);
      got  = (q_upd.size() > i) ? q_upd[i] : -1;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL b2b_update blk=%0d got=%0d want=%0d", i, got, want);
      end
    end
    if (!rnd && nblk > 1) begin
      checks++;
      if (acc_q[1] !== q_upd[0] + 1) begin
        failures++;
        $display("FAIL b2b_ready_gap acc=%0d want=%0d", acc_q[1], q_upd[0] + 1);
      end
    end
    checks++;
    if (n_hinit !== 1 || n_load !== nblk || n_upd !== nblk) begin
      failures++;
      $display("FAIL b2b_strobes hinit=%0d load=%0d upd=%0d want 1/%0d/%0d",
               n_hinit, n_load, n_upd, nblk, nblk);
    end
    checks++;
    if (blk_cnt !== 16'(nblk) || n_dv !== 1 || c_dv !== q_upd[nblk-1] + 1) begin
      failures++;
      $display("FAIL b2b_digest cnt=%0d ndv=%0d dv_cyc=%0d want cnt=%0d ndv=1 dv_cyc=%0d",
               blk_cnt, n_dv, c_dv, nblk, q_upd[nblk-1] + 1);
    end
    repeat ($urandom_range(0, 5)) tick();
    checks++;
    if (digest_valid !== 1'b1 || blk_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_hold dv=%b ready=%b want dv=1 ready=0", digest_valid, blk_ready);
    end
    ack_digest();
  endtask

  task automatic test_abort(input int at);
    int acc;
    int u;
    bit ok;
    bit found;
    clear_rec();
    offer_block(1'b1, 10, acc, ok);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (round_en && round_t == 6'(at)) begin found = 1'b1; break; end
      tick();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL abort_reach t=%0d got=timeout want=round", at); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (blk_ready !== 1'b1 || busy !== 1'b0 || round_en !== 1'b0 || round_t !== 6'd0) begin
      failures++;
      $display("FAIL abort_idle ready=%b busy=%b ren=%b t=%0d want 1/0/0/0",
               blk_ready, busy, round_en, round_t);
    end
    repeat (80) tick();
    checks++;
    if (n_upd !== 0 || digest_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_noupd upd=%0d dv=%b want 0/0", n_upd, digest_valid);
    end
    abort = 1'b1;
    repeat (3) tick();
    abort = 1'b0;
    checks++;
    if (blk_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_idle ready=%b busy=%b want 1/0", blk_ready, busy);
    end
    clear_rec();
    offer_block(1'b1, 10, acc, ok);
    wait_dv(200, ok);
    u = (q_upd.size() > 0) ? q_upd[0] : -1;
    checks++;
    if (c_hinit !== acc + 1 || u !== acc + 67 || blk_cnt !== 16'd1) begin
      failures++;
      $display("FAIL abort_restart hinit=%0d upd=%0d cnt=%0d want %0d/%0d/1",
               c_hinit, u, blk_cnt, acc + 1, acc + 67);
    end
    ack_digest();
  endtask

  task automatic test_async_reset();
    int acc;
    int u;
    bit ok;
    bit found;
    clear_rec();
    offer_block(1'b1, 10, acc, ok);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (round_en && round_t == 6'd45) begin found = 1'b1; break; end
      tick();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL areset_reach got=timeout want=round45"); end
    #3;
    chk_busy = 0;
    reset = 1'b1;
    #1;
    checks++;
    if ({h_init, wv_load, round_en, h_update, digest_valid, busy, blk_ready} !== 7'b0
        || round_t !== 6'd0 || blk_cnt !== 16'd0) begin
      failures++;
      $display("FAIL areset_immediate outs=%b t=%0d cnt=%0d want 0",
               {h_init, wv_load, round_en, h_update, digest_valid, busy, blk_ready},
               round_t, blk_cnt);
    end
    #2;
    reset = 1'b0;
    tick();
    checks++;
    if (blk_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL areset_release ready=%b busy=%b want 1/0", blk_ready, busy);
    end
    chk_busy = 1;
    clear_rec();
    offer_block(1'b1, 10, acc, ok);
    wait_dv(200, ok);
    u = (q_upd.size() > 0) ? q_upd[0] : -1;
    checks++;
    if (c_hinit !== acc + 1 || u !== acc + 67 || blk_cnt !== 16'd1) begin
      failures++;
      $display("FAIL areset_restart hinit=%0d upd=%0d cnt=%0d want %0d/%0d/1",
               c_hinit, u, blk_cnt, acc + 1, acc + 67);
    end
    ack_digest();
  endtask

  task automatic test_done_hold();
    int acc;
    int bad;
    int u;
    bit ok;
    clear_rec();
    offer_block(1'b1, 10, acc, ok);
    wait_dv(200, ok);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (digest_valid !== 1'b1 || blk_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL done_hold bad_cycles=%0d want=0", bad); end
    digest_ack = 1'b1;
    blk_valid  = 1'b1;
    blk_last   = 1'b1;
    tick();
    digest_ack = 1'b0;
    checks++;
    if (digest_valid !== 1'b0 || blk_ready !== 1'b1 || h_init !== 1'b0 || n_hinit !== 1) begin
      failures++;
      $display("FAIL done_ack_same dv=%b ready=%b hinit=%b n=%0d want 0/1/0/1",
               digest_valid, blk_ready, h_init, n_hinit);
    end
    acc = cyc;
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    checks++;
    if (h_init !== 1'b1 || n_hinit !== 2) begin
      failures++;
      $display("FAIL done_next_accept hinit=%b n=%0d want 1/2", h_init, n_hinit);
    end
    wait_dv(200, ok);
    u = (q_upd.size() > 1) ? q_upd[1] : -1;
    checks++;
    if (u !== acc + 67) begin
      failures++;
      $display("FAIL done_next_update got=%0d want=%0d", u, acc + 67);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (digest_valid !== 1'b0 || blk_ready !== 1'b1) begin
      failures++;
      $display("FAIL done_abort_ack dv=%b ready=%b want 0/1", digest_valid, blk_ready);
    end
  endtask

  task automatic test_small_rounds();
    int acc;
    int nre;
    int sbad;
    int exp_t;
    int cu;
    int cd;
    acc = -1;
    v2 = 1'b1;
    l2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rdy2) begin acc = cyc; break; end
      tick();
    end
    tick();
    v2 = 1'b0;
    l2 = 1'b0;
    checks++;
    if (acc < 0) begin failures++; $display("FAIL r8_accept got=timeout want=accept"); end
    nre = 0; sbad = 0; exp_t = 0; cu = -1; cd = -1;
    for (int i = 0; i < 20; i++) begin
      if (re2) begin
        nre++;
        if (rt2 !== 3'(exp_t)) sbad++;
        exp_t++;
      end
      if (hu2 && cu < 0) cu = cyc;
      if (dv2 && cd < 0) cd = cyc;
      tick();
    end
    checks++;
    if (nre !== 8 || sbad !== 0) begin
      failures++;
      $display("FAIL r8_rounds n=%0d bad_idx=%0d want 8/0", nre, sbad);
    end
    checks++;
    if (cu !== acc + 11 || cd !== acc + 12 || bc2 !== 16'd1) begin
      failures++;
      $display("FAIL r8_timing upd=%0d dv=%0d cnt=%0d want %0d/%0d/1", cu, cd, bc2, acc + 11, acc + 12);
    end
    ack2 = 1'b1;
    tick();
    ack2 = 1'b0;
    checks++;
    if (dv2 !== 1'b0 || rdy2 !== 1'b1) begin
      failures++;
      $display("FAIL r8_ack dv=%b ready=%b want 0/1", dv2, rdy2);
    end
  endtask

  task automatic test_strobes();
    checks++;
    if (excl_bad !== 0) begin
      failures++;
      $display("FAIL strobe_exclusive bad_cycles=%0d want=0", excl_bad);
    end
    checks++;
    if (busy_bad !== 0) begin
      failures++;
      $display("FAIL busy_vs_state bad_cycles=%0d want=0", busy_bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back(2, 1'b0);
    test_back_to_back(3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      test_back_to_back(int'($urandom_range(1, 3)), 1'b1);
    end
    test_abort(30);
    test_abort(int'($urandom_range(0, R - 1)));
    test_async_reset();
    test_done_hold();
    test_small_rounds();
    test_strobes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
